division_param: RTL and testbench
=================================

// Module: division_param
// PURPOSE
//  Parametrised multi-cycle integer divider; runtime-selectable signed/unsigned mode.
//  Restoring radix-2, one quotient bit per clock.
//  Operands are latched at start, so callers need not hold them.
//  Flags divide-by-zero and signed overflow; registered result with busy/finish handshake.
//  Sits beside the ALU as the long-latency DIV/DIVU/REM/REMU unit.
// PARAMETERS
//  WIDTH  32  operand width in bits, >=2; step counter is $clog2(WIDTH+1) bits
// PORTS
//  clock        in   1        rising-edge clock
//  reset        in   1        synchronous, active-high reset
//  start        in   1        request; accepted only when busy=0
//  signed_mode  in   1        1: two's-complement divide, 0: unsigned; latched at accept
//  operand1     in   WIDTH    dividend, latched at accept
//  operand2     in   WIDTH    divisor, latched at accept
//  busy         out  1        1 from accept until the edge that raises finish
//  finish       out  1        one-cycle pulse: result/flags valid
//  result       out  2*WIDTH  [WIDTH-1:0] quotient, [2*WIDTH-1:WIDTH] remainder; held until next accept
//  illegal      out  1        divisor was zero (registered with result)
//  overflow     out  1        signed MIN / -1 (registered with result)
// BEHAVIOUR
//  Reset (sync, priority over everything, incl. mid-operation):
//   - state=IDLE; busy=0, finish=0, result=0, illegal=0, overflow=0.
//   - Any in-flight op is discarded; no finish pulse follows.
//  FSM: IDLE -> CALC -> DONE -> IDLE.
//  IDLE:
//   - start=1 at edge T: latch mode/operands.
//   - Convert to magnitudes if signed_mode; record sign of quotient (s1^s2) and remainder (s1).
//   - Clear step; busy=1.
//   - Divisor==0 -> DONE directly (skip CALC).
//   - Otherwise -> CALC.
//  CALC, edges T+1..T+WIDTH, one per edge:
//   - {rem,quo} <<= 1.
//   - If rem >= |divisor|: rem -= |divisor|, quo[0]=1.
//   - Exit to DONE when step == WIDTH-1 on that edge.
//   - Partial remainder is WIDTH+1 bits to avoid compare overflow.
//  DONE edge (T+WIDTH+1 normal; T+1 for div-by-zero):
//   - Apply signs (two's-complement negate); load result/illegal/overflow.
//   - finish=1 for exactly that one cycle; busy=0; -> IDLE.
//  Latency: finish high in the cycle after edge T+WIDTH+1 (WIDTH+2 edges from accept).
//   - Divide-by-zero: finish after edge T+1.
//  start while busy=1: ignored, no effect on the in-flight op.
//  start on the finish cycle (busy=0): accepted; finish drops next cycle.
//  Divide-by-zero: quotient = all ones, remainder = operand1 unmodified, illegal=1, overflow=0.
//  Signed overflow (signed_mode, operand1=100..0, operand2=all ones):
//   - quotient = 100..0, remainder = 0, overflow=1.
//   - Normal latency; falls out of the magnitude path naturally.
//  Signed results truncate toward zero; remainder takes dividend's sign; |rem| < |divisor|.
//  illegal/overflow are 0 on every other completion; both held with result.
// TESTING
//  1. WIDTH=32, signed, -7 / 2.
//     -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
//     -> finish exactly 34 edges after accept; busy high in between.
//  2. WIDTH=32, unsigned, 0xFFFFFFF9 / 2.
//     -> quotient=0x7FFFFFFC, remainder=0x00000001, illegal=0, overflow=0.
//  3. WIDTH=32, 100 / 0 (either mode).
//     -> quotient=0xFFFFFFFF, remainder=100, illegal=1, finish 2 edges after accept.
//  4. WIDTH=32, signed, 0x80000000 / 0xFFFFFFFF.
//     -> quotient=0x80000000, remainder=0, overflow=1.
//  5. WIDTH=8, signed, 0x80 (-128) / 3 -> quotient=0xD6 (-42), remainder=0xFE (-2).
//     Second start pulsed mid-CALC is ignored (single finish pulse).
//  6. Reset asserted 10 edges into a 32-bit op.
//     -> next cycle busy=0, finish=0, result=0, no stray finish.
//     -> new op 50/7 after reset gives quotient=7, remainder=1.

Source files
------------

// File: rtl/division_param.sv
// Multi-cycle restoring radix-2 divider with runtime signed/unsigned mode.
// Ports: clock, reset (sync, active-high), start, signed_mode, operand1 (dividend),
//   operand2 (divisor) -> busy, finish (1-cycle pulse), result {rem,quo},
//   illegal (divide-by-zero), overflow (signed MIN / -1).
module division_param #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   operand1,
  input  logic [WIDTH-1:0]   operand2,
  output logic               busy,
  output logic               finish,
  output logic [2*WIDTH-1:0] result,
  output logic               illegal,
  output logic               overflow
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   dvd_q;
  logic [SW-1:0]      step_q;
  logic               negq_q;
  logic               negr_q;
  logic               zero_q;
  logic               ovf_q;
  logic               busy_q;
  logic               finish_q;
  logic [2*WIDTH-1:0] result_q;
  logic               illegal_q;
  logic               overflow_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sh_d;
  logic [WIDTH:0]     sub_d;
  logic               ge_d;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   q_fin;
  logic [WIDTH-1:0]   r_fin;

  // Magnitudes; MIN maps onto itself, which is correct as an unsigned value.
  assign a_mag = (signed_mode && operand1[WIDTH-1]) ? -operand1 : operand1;
  assign b_mag = (signed_mode && operand2[WIDTH-1]) ? -operand2 : operand2;

  // One restoring step; the shifted remainder needs an extra bit.
  assign sh_d  = {rem_q, quo_q[WIDTH-1]};
  assign sub_d = sh_d - {1'b0, dvs_q};
  assign ge_d  = (sh_d >= {1'b0, dvs_q});
  assign rem_d = ge_d ? sub_d[WIDTH-1:0] : sh_d[WIDTH-1:0];
  assign quo_d = {quo_q[WIDTH-2:0], ge_d};

  assign q_fin = negq_q ? -quo_q : quo_q;
  assign r_fin = negr_q ? -rem_q : rem_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dvd_q      <= '0;
      step_q     <= '0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
      result_q   <= '0;
      illegal_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q  <= operand1;
            quo_q  <= a_mag;
            dvs_q  <= b_mag;
            rem_q  <= '0;
            negq_q <= signed_mode &
                      (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
            negr_q <= signed_mode & operand1[WIDTH-1];
            zero_q <= (operand2 == '0);
            ovf_q  <= signed_mode && (operand1 == MIN) &&
                      (&operand2);
            step_q <= '0;
            busy_q <= 1'b1;
            state_q <= (operand2 == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          rem_q  <= rem_d;
          quo_q  <= quo_d;
          step_q <= step_q + 1'b1;
          if (step_q == LAST) state_q <= DONE;
        end
        DONE: begin
          if (zero_q) begin
            result_q   <= {dvd_q, {WIDTH{1'b1}}};
            illegal_q  <= 1'b1;
            overflow_q <= 1'b0;
          end else begin
            result_q   <= {r_fin, q_fin};
            illegal_q  <= 1'b0;
            overflow_q <= ovf_q;
          end
          finish_q <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign finish   = finish_q;
  assign result   = result_q;
  assign illegal  = illegal_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_division_param.sv
// Directed bench for division_param (32-bit and 8-bit instances).
// Checks results, flags, latency, handshake, ignored starts and reset.
module tb_division_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        st32, sm32;
  logic [31:0] a32, b32;
  logic        busy32, fin32, ill32, ovf32;
  logic [63:0] res32;
  logic        st8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, fin8, ill8, ovf8;
  logic [15:0] res8;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  division_param #(.WIDTH(32)) u_div32 (
    .clock(clk), .reset(rst), .start(st32), .signed_mode(sm32),
    .operand1(a32), .operand2(b32), .busy(busy32), .finish(fin32),
    .result(res32), .illegal(ill32), .overflow(ovf32)
  );

  division_param #(.WIDTH(8)) u_div8 (
    .clock(clk), .reset(rst), .start(st8), .signed_mode(sm8),
    .operand1(a8), .operand2(b8), .busy(busy8), .finish(fin8),
    .result(res8), .illegal(ill8), .overflow(ovf8)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one 32-bit op; returns in the finish cycle with the edge count
  // (accept edge = 1), or -1 if finish never came.
  task automatic run32(input logic sm, input logic [31:0] a,
                       input logic [31:0] b, output int edges);
    int   n;
    logic bb;
    bb = 1'b0;
    sm32 = sm; a32 = a; b32 = b; st32 = 1'b1;
    @(posedge clk); #1;
    st32 = 1'b0;
    n = 1;
    while (!fin32 && n < 100) begin
      if (!busy32) bb = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    edges = fin32 ? n : -1;
    chk("busy_held", {63'd0, bb}, 64'd0);
    chk("busy_at_fin", {63'd0, busy32}, 64'd0);
  endtask

  initial begin
    int   e;
    int   nfin;
    int   lat8;
    int   stray;
    logic [15:0] r8;

    rst = 1'b1;
    st32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
    st8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy32}, 64'd0);
    chk("rst_fin", {63'd0, fin32}, 64'd0);
    chk("rst_res", res32, 64'd0);
    chk("rst_flags", {62'd0, ill32, ovf32}, 64'd0);
    chk("rst8_res", {48'd0, res8}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // -7 / 2 signed
    run32(1'b1, 32'hFFFF_FFF9, 32'd2, e);
    chk("t1_lat", 64'(e), 64'd34);
    chk("t1_res", res32, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    chk("t1_flags", {62'd0, ill32, ovf32}, 64'd0);
    @(posedge clk); #1;
    chk("t1_fin_drop", {63'd0, fin32}, 64'd0);
    chk("t1_res_hold", res32, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // unsigned 0xFFFFFFF9 / 2
    run32(1'b0, 32'hFFFF_FFF9, 32'd2, e);
    chk("t2_lat", 64'(e), 64'd34);
    chk("t2_res", res32, {32'h0000_0001, 32'h7FFF_FFFC});
    chk("t2_flags", {62'd0, ill32, ovf32}, 64'd0);

    // 100 / 0, started in the finish cycle of the previous op
    run32(1'b0, 32'd100, 32'd0, e);
    chk("t3_lat", 64'(e), 64'd2);
    chk("t3_res", res32, {32'd100, 32'hFFFF_FFFF});
    chk("t3_flags", {62'd0, ill32, ovf32}, 64'd2);

    // signed -5 / 0: remainder is the raw dividend
    run32(1'b1, 32'hFFFF_FFFB, 32'd0, e);
    chk("t3s_lat", 64'(e), 64'd2);
    chk("t3s_res", res32, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    chk("t3s_flags", {62'd0, ill32, ovf32}, 64'd2);

    // signed MIN / -1
    run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, e);
    chk("t4_lat", 64'(e), 64'd34);
    chk("t4_res", res32, {32'd0, 32'h8000_0000});
    chk("t4_flags", {62'd0, ill32, ovf32}, 64'd1);

    // 8-bit signed -128 / 3, with an ignored second start mid-CALC
    sm8 = 1'b1; a8 = 8'h80; b8 = 8'd3; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    nfin = 0; lat8 = -1; r8 = '0;
    for (int i = 1; i <= 30; i++) begin
      st8 = (i == 3);
      if (i == 3) begin
        sm8 = 1'b0; a8 = 8'd5; b8 = 8'd1;
      end
      @(posedge clk); #1;
      if (fin8) begin
        nfin++;
        if (lat8 < 0) begin
          lat8 = i + 1;
          r8 = res8;
        end
      end
    end
    st8 = 1'b0;
    chk("t5_npulse", 64'(nfin), 64'd1);
    chk("t5_lat", 64'(lat8), 64'd10);
    chk("t5_res", {48'd0, r8}, {48'd0, 16'hFED6});
    chk("t5_flags", {62'd0, ill8, ovf8}, 64'd0);

    // reset 10 edges into a 32-bit op
    sm32 = 1'b1; a32 = 32'd1000; b32 = 32'd3; st32 = 1'b1;
    @(posedge clk); #1;
    st32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("t6_busy_pre", {63'd0, busy32}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_busy", {63'd0, busy32}, 64'd0);
    chk("t6_fin", {63'd0, fin32}, 64'd0);
    chk("t6_res", res32, 64'd0);
    chk("t6_flags", {62'd0, ill32, ovf32}, 64'd0);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (fin32) stray++;
    end
    chk("t6_stray", 64'(stray), 64'd0);
    run32(1'b0, 32'd50, 32'd7, e);
    chk("t6_lat", 64'(e), 64'd34);
    chk("t6_res2", res32, {32'd1, 32'd7});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
